io_stage: RTL and testbench
===========================

# io_stage

Memory-access (IO) stage of the five-stage MIPS core, between EX and WB. Holds one instruction per cycle under a valid/allowin handshake and selects the final result: ALU result, or load data from the synchronous data SRAM. It also captures SRAM read data when WB stalls, so the value is never lost. It drives the IO→WB bus and the IO→ID forwarding bus.

## Interface
Parameters:
- none; all widths come from `io_stage_params` / `ex_stage_params` (`CpuData` = 32 bits).

Ports:
- `clock`  in  1  single clock; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_to_io_bus`  in  EXToIOData (72)  EX payload; `.valid` is the EX ready-to-hand-over flag.
- `io_allowin`  out  1  IO can accept a new instruction this cycle.
- `wb_allowin`  in  1  WB can accept an instruction this cycle.
- `data_sram_rdata`  in  32  data SRAM read data, valid only in the cycle after EX issued the read.
- `io_to_wb_bus`  out  IOToWBData (71)  registered stage contents, with `final_result` resolved.
- `io_to_id_back_pass_bus`  out  IOToIDBackPassData (38)  forwarding information to ID.

## Operation
State registers:
- `io_valid`
- `io_payload` (program_count, alu_result, destination_register, register_write, result_is_from_memory)
- `first_cycle`
- `load_buffer_valid`
- `load_buffer[31:0]`

Handshake:
- `io_ready_go` = 1 (IO never self-stalls).
- `io_allowin` = !io_valid || wb_allowin.
- Leave event: io_valid && wb_allowin.
- Accept event: io_allowin && ex_to_io_bus.valid.
- When io_allowin: io_valid <= ex_to_io_bus.valid. Otherwise io_valid holds.
- On accept: io_payload <= bus fields, first_cycle <= 1, load_buffer_valid <= 0.
- Payload registers load only on accept; they hold otherwise, including across bubbles.

Load capture:
- first_cycle clears on any cycle without an accept.
- Capture condition: io_valid && first_cycle && result_is_from_memory && !wb_allowin. Then load_buffer <= data_sram_rdata and load_buffer_valid <= 1.
- load_buffer_valid stays set until the next accept or reset.

Result select (combinational):
- final_result = result_is_from_memory ? (load_buffer_valid ? load_buffer : data_sram_rdata) : alu_result.

Output mapping:
- io_to_wb_bus: valid = io_valid; program_count, register_file_address = destination_register, register_file_write_enabled = register_write, final_result.
- back-pass: valid = io_valid && register_write && destination_register != 0; write_register = destination_register; write_data = final_result. This output is always data-valid.

## Timing
- Reset (synchronous): io_valid, first_cycle, load_buffer_valid, load_buffer and every payload register go to 0.
- Outputs while in reset:
  - io_to_wb_bus all zero
  - back-pass all zero
  - io_allowin = 1
- Reset mid-operation: the held instruction and any buffered load are discarded. No WB handover occurs in the reset cycle's aftermath.
- Latency: an instruction accepted at edge N is visible on io_to_wb_bus from cycle N to N+1. It leaves at the first edge with wb_allowin = 1. Minimum residency is one cycle.
- Combinational paths:
  - wb_allowin → io_allowin
  - data_sram_rdata → final_result (first cycle only)
  - No other input→output paths exist.
- Simultaneous leave + accept: the new instruction replaces the old one in the same edge. first_cycle is set, load_buffer_valid is cleared, and there is no bubble.
- Leave with no new valid: io_valid <= 0 and a bubble follows.
- WB stall lasting k cycles on a load: data_sram_rdata is captured in the first cycle only. final_result stays constant for all k+1 cycles, regardless of later rdata values.
- Stall on a non-load: alu_result is held, and data_sram_rdata is ignored.

## Test plan
- Reset held 2 cycles with ex valid = 1 → io_to_wb_bus.valid = 0, back-pass valid = 0, io_allowin = 1. The first instruction is accepted on the first edge after reset deasserts.
- ALU op pc=0xBFC00000, alu_result=0x1234, dest=5, regwrite=1, wb_allowin=1 → the next cycle shows WB final_result=0x1234, addr 5, and back-pass valid=1 with data 0x1234. The cycle after shows valid=0.
- Load dest=8 with rdata=0xDEADBEEF in its first cycle, wb_allowin=0 for 3 cycles while rdata changes to 0x0 → final_result stays 0xDEADBEEF every cycle, io_allowin=0, and the instruction hands over on the 4th cycle.
- Back-to-back stream of 4 ALU ops with wb_allowin=1 throughout → 4 consecutive WB-valid cycles with matching pcs in order and no bubbles.
- dest=0 with regwrite=1 → back-pass valid=0, WB register_file_write_enabled=1, address 0.
- Load stalled with the buffer filled, then a new load accepted in the leave cycle with rdata=0x55AA55AA → the new final_result is 0x55AA55AA, not the stale buffer contents.

Source files
------------

// File: rtl/io_stage.sv
// Memory-access (IO) stage of the five-stage MIPS core, sitting between EX and WB.
// It holds one instruction under a valid/allowin handshake and resolves the final
// result from either the ALU result or the synchronous data SRAM read data. SRAM
// data is captured into a local buffer if WB stalls during the load's first cycle.

package ex_stage_params;
    typedef logic [31:0] CpuData;
    typedef logic [4:0]  RegAddr;

    typedef struct packed {
        logic   valid;
        CpuData program_count;
        CpuData alu_result;
        RegAddr destination_register;
        logic   register_write;
        logic   result_is_from_memory;
    } EXToIOData;
endpackage

package io_stage_params;
    typedef struct packed {
        logic                   valid;
        ex_stage_params::CpuData program_count;
        ex_stage_params::RegAddr register_file_address;
        logic                   register_file_write_enabled;
        ex_stage_params::CpuData final_result;
    } IOToWBData;

    typedef struct packed {
        logic                   valid;
        ex_stage_params::RegAddr write_register;
        ex_stage_params::CpuData write_data;
    } IOToIDBackPassData;

    typedef struct packed {
        ex_stage_params::CpuData program_count;
        ex_stage_params::CpuData alu_result;
        ex_stage_params::RegAddr destination_register;
        logic                   register_write;
        logic                   result_is_from_memory;
    } IOPayload;
endpackage

module io_stage
    import ex_stage_params::*;
    import io_stage_params::*;
(
    input  logic              clock,
    input  logic              reset,
    input  EXToIOData         ex_to_io_bus,
    output logic              io_allowin,
    input  logic              wb_allowin,
    input  logic [31:0]       data_sram_rdata,
    output IOToWBData         io_to_wb_bus,
    output IOToIDBackPassData io_to_id_back_pass_bus
);

    logic        io_valid_q,          io_valid_d;
    IOPayload    io_payload_q,        io_payload_d;
    logic        first_cycle_q,       first_cycle_d;
    logic        load_buffer_valid_q, load_buffer_valid_d;
    logic [31:0] load_buffer_q,       load_buffer_d;

    logic        accept;
    CpuData      final_result;

    // Handshake, payload load on accept, and first-cycle load capture.
    always_comb begin
        io_allowin          = !io_valid_q || wb_allowin;
        accept              = io_allowin && ex_to_io_bus.valid;

        io_valid_d          = io_valid_q;
        io_payload_d        = io_payload_q;
        first_cycle_d       = 1'b0;
        load_buffer_valid_d = load_buffer_valid_q;
        load_buffer_d       = load_buffer_q;

        if (io_allowin) begin
            io_valid_d = ex_to_io_bus.valid;
        end

        if (accept) begin
            io_payload_d.program_count         = ex_to_io_bus.program_count;
            io_payload_d.alu_result            = ex_to_io_bus.alu_result;
            io_payload_d.destination_register  = ex_to_io_bus.destination_register;
            io_payload_d.register_write        = ex_to_io_bus.register_write;
            io_payload_d.result_is_from_memory = ex_to_io_bus.result_is_from_memory;
            first_cycle_d                      = 1'b1;
            load_buffer_valid_d                = 1'b0;
        end else if (io_valid_q && first_cycle_q &&
                     io_payload_q.result_is_from_memory && !wb_allowin) begin
            // SRAM data is only presented in the load's first cycle; keep it for the stall.
            load_buffer_d       = data_sram_rdata;
            load_buffer_valid_d = 1'b1;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_valid_q          <= 1'b0;
            io_payload_q        <= '0;
            first_cycle_q       <= 1'b0;
            load_buffer_valid_q <= 1'b0;
            load_buffer_q       <= '0;
        end else begin
            io_valid_q          <= io_valid_d;
            io_payload_q        <= io_payload_d;
            first_cycle_q       <= first_cycle_d;
            load_buffer_valid_q <= load_buffer_valid_d;
            load_buffer_q       <= load_buffer_d;
        end
    end

    // Result select and output bus mapping.
    always_comb begin
        if (io_payload_q.result_is_from_memory) begin
            final_result = load_buffer_valid_q ? load_buffer_q : data_sram_rdata;
        end else begin
            final_result = io_payload_q.alu_result;
        end

        io_to_wb_bus.valid                       = io_valid_q;
        io_to_wb_bus.program_count               = io_payload_q.program_count;
        io_to_wb_bus.register_file_address       = io_payload_q.destination_register;
        io_to_wb_bus.register_file_write_enabled = io_payload_q.register_write;
        io_to_wb_bus.final_result                = final_result;

        io_to_id_back_pass_bus.valid          = io_valid_q && io_payload_q.register_write &&
                                                (io_payload_q.destination_register != 5'd0);
        io_to_id_back_pass_bus.write_register = io_payload_q.destination_register;
        io_to_id_back_pass_bus.write_data     = final_result;
    end

endmodule

// File: tb/tb_io_stage.sv
// Directed bench for io_stage with a scoreboard of expected WB handovers.
module tb_io_stage;
    import ex_stage_params::*;
    import io_stage_params::*;

    logic              clock = 1'b0;
    logic              reset;
    EXToIOData         ex_to_io_bus;
    logic              io_allowin;
    logic              wb_allowin;
    logic [31:0]       data_sram_rdata;
    IOToWBData         io_to_wb_bus;
    IOToIDBackPassData io_to_id_back_pass_bus;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic        we;
        logic [31:0] result;
        logic        bp_valid;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_result;
    int          checks = 0;
    int          errors = 0;

    io_stage dut (
        .clock                  (clock),
        .reset                  (reset),
        .ex_to_io_bus           (ex_to_io_bus),
        .io_allowin             (io_allowin),
        .wb_allowin             (wb_allowin),
        .data_sram_rdata        (data_sram_rdata),
        .io_to_wb_bus           (io_to_wb_bus),
        .io_to_id_back_pass_bus (io_to_id_back_pass_bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [4:0] dest, input logic rw, input logic mem,
                         input logic [31:0] res);
        ex_to_io_bus.valid                 = v;
        ex_to_io_bus.program_count         = pc;
        ex_to_io_bus.alu_result            = alu;
        ex_to_io_bus.destination_register  = dest;
        ex_to_io_bus.register_write        = rw;
        ex_to_io_bus.result_is_from_memory = mem;
        exp_result                         = res;
    endtask

    // One clock: at the negedge push accepted work and pop/compare handovers,
    // then advance past the posedge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (!reset && io_to_wb_bus.valid && wb_allowin) begin
            if (sb.size() == 0) begin
                chk("unexpected_handover", io_to_wb_bus.program_count, 32'hxxxxxxxx);
            end else begin
                e = sb.pop_front();
                chk("sb_pc",       io_to_wb_bus.program_count, e.pc);
                chk("sb_addr",     {27'd0, io_to_wb_bus.register_file_address}, {27'd0, e.addr});
                chk("sb_we",       {31'd0, io_to_wb_bus.register_file_write_enabled}, {31'd0, e.we});
                chk("sb_result",   io_to_wb_bus.final_result, e.result);
                chk("sb_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, {31'd0, e.bp_valid});
                chk("sb_bp_data",  io_to_id_back_pass_bus.write_data, e.result);
            end
        end
        if (!reset && ex_to_io_bus.valid && io_allowin) begin
            e.pc       = ex_to_io_bus.program_count;
            e.addr     = ex_to_io_bus.destination_register;
            e.we       = ex_to_io_bus.register_write;
            e.result   = exp_result;
            e.bp_valid = ex_to_io_bus.register_write && (ex_to_io_bus.destination_register != 5'd0);
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        wb_allowin      = 1'b1;
        data_sram_rdata = 32'h0;
        drive(1'b1, 32'hBFC00000, 32'h1234, 5'd5, 1'b1, 1'b0, 32'h1234);

        // Reset held two cycles with EX valid
        tick();
        tick();
        chk("rst_wb_valid", {31'd0, io_to_wb_bus.valid}, 32'd0);
        chk("rst_wb_bus",   io_to_wb_bus.final_result | io_to_wb_bus.program_count, 32'd0);
        chk("rst_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, 32'd0);
        chk("rst_allowin",  {31'd0, io_allowin}, 32'd1);
        reset = 1'b0;

        // First ALU op accepted on the first edge after reset
        tick();
        chk("alu_valid",    {31'd0, io_to_wb_bus.valid}, 32'd1);
        chk("alu_result",   io_to_wb_bus.final_result, 32'h1234);
        chk("alu_addr",     {27'd0, io_to_wb_bus.register_file_address}, 32'd5);
        chk("alu_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, 32'd1);
        chk("alu_bp_data",  io_to_id_back_pass_bus.write_data, 32'h1234);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("alu_bubble", {31'd0, io_to_wb_bus.valid}, 32'd0);

        // Load with a three-cycle WB stall; rdata changes after the first cycle
        drive(1'b1, 32'h00000100, 32'h0000AAAA, 5'd8, 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        data_sram_rdata = 32'hDEADBEEF;
        wb_allowin      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_stall_result",  io_to_wb_bus.final_result, 32'hDEADBEEF);
            chk("ld_stall_allowin", {31'd0, io_allowin}, 32'd0);
            tick();
            data_sram_rdata = 32'h0;
        end
        wb_allowin = 1'b1;
        #1;
        chk("ld_leave_result",  io_to_wb_bus.final_result, 32'hDEADBEEF);
        chk("ld_leave_allowin", {31'd0, io_allowin}, 32'd1);
        tick();
        chk("ld_bubble", {31'd0, io_to_wb_bus.valid}, 32'd0);

        // Back-to-back stream of four ALU ops
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h00000200 + 32'(i * 4), 32'h00001000 + 32'(i), 5'(i + 1),
                  1'b1, 1'b0, 32'h00001000 + 32'(i));
            tick();
            chk("stream_valid", {31'd0, io_to_wb_bus.valid}, 32'd1);
            chk("stream_pc",    io_to_wb_bus.program_count, 32'h00000200 + 32'(i * 4));
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("stream_bubble", {31'd0, io_to_wb_bus.valid}, 32'd0);

        // Write to r0: no forwarding, WB still sees the write
        drive(1'b1, 32'h00000300, 32'h77, 5'd0, 1'b1, 1'b0, 32'h77);
        tick();
        chk("r0_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, 32'd0);
        chk("r0_we",       {31'd0, io_to_wb_bus.register_file_write_enabled}, 32'd1);
        chk("r0_addr",     {27'd0, io_to_wb_bus.register_file_address}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        tick();

        // Non-load stall ignores rdata
        drive(1'b1, 32'h00000400, 32'h0000CAFE, 5'd3, 1'b1, 1'b0, 32'h0000CAFE);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        wb_allowin      = 1'b0;
        data_sram_rdata = 32'hFFFFFFFF;
        tick();
        chk("alu_stall_result", io_to_wb_bus.final_result, 32'h0000CAFE);
        chk("alu_stall_valid",  {31'd0, io_to_wb_bus.valid}, 32'd1);
        wb_allowin = 1'b1;
        tick();

        // Stalled load with buffer filled, new load accepted in the leave cycle
        drive(1'b1, 32'h00000500, 32'h0, 5'd9, 1'b1, 1'b1, 32'h11111111);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        data_sram_rdata = 32'h11111111;
        wb_allowin      = 1'b0;
        tick();
        data_sram_rdata = 32'h0;
        wb_allowin      = 1'b1;
        drive(1'b1, 32'h00000504, 32'h0, 5'd10, 1'b1, 1'b1, 32'h55AA55AA);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        data_sram_rdata = 32'h55AA55AA;
        #1;
        chk("ld2_pc",     io_to_wb_bus.program_count, 32'h00000504);
        chk("ld2_result", io_to_wb_bus.final_result, 32'h55AA55AA);
        tick();

        // Reset mid-operation discards a stalled, buffered load
        drive(1'b1, 32'h00000600, 32'h0, 5'd4, 1'b1, 1'b1, 32'h12345678);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        data_sram_rdata = 32'h12345678;
        wb_allowin      = 1'b0;
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        reset      = 1'b0;
        wb_allowin = 1'b1;
        #1;
        chk("midrst_valid",   {31'd0, io_to_wb_bus.valid}, 32'd0);
        chk("midrst_result",  io_to_wb_bus.final_result, 32'd0);
        chk("midrst_allowin", {31'd0, io_allowin}, 32'd1);
        tick();
        chk("midrst_no_handover", {31'd0, io_to_wb_bus.valid}, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
